// File: rtl/uart_rx_packet_ctrl.sv
// UART byte-stream packet framer: SYNC, LEN, payload, CSUM.
// Buffers a good packet and drains it over a valid/ready port.
module uart_rx_packet_ctrl #(
  parameter int          MAX_LEN = 8,
  parameter int          TIMEOUT = 104166,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic       CLK50MHz,
  input  logic       RESET,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  input  logic       RX_PERR,
  output logic [7:0] PKT_DATA,
  output logic       PKT_VALID,
  input  logic       PKT_READY,
  output logic       PKT_LAST,
  output logic       ERR,
  output logic [2:0] ERR_CODE,
  output logic [7:0] ERR_COUNT
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, LEN, PAYLOAD, CSUM, DRAIN
  } state_t;

  state_t          state, nstate;
  logic [7:0]      len_q;
  logic [AW-1:0]   idx, rd;
  logic [7:0]      sum;
  logic [TW-1:0]   tcnt;
  logic [7:0]      mem [MAX_LEN];

  logic            err_n;
  logic [2:0]      code_n;
  logic            ld_len, wr, run, hs;
  logic [7:0]      last_idx;

  assign last_idx  = len_q - 8'd1;
  assign run       = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
  assign hs        = (state == DRAIN) && PKT_READY;
  assign PKT_VALID = (state == DRAIN);
  assign PKT_DATA  = PKT_VALID ? mem[rd] : 8'd0;
  assign PKT_LAST  = PKT_VALID && (8'(rd) == last_idx);

  always_comb begin
    nstate = state;
    err_n  = 1'b0;
    code_n = 3'd0;
    ld_len = 1'b0;
    wr     = 1'b0;
    case (state)
      IDLE: begin
        if (RX_VALID && !RX_PERR && RX_DATA == SYNC)
          nstate = LEN;
      end
      LEN, PAYLOAD, CSUM: begin
        if (RX_VALID) begin
          if (RX_PERR) begin
            err_n  = 1'b1;
            code_n = 3'd4;
            nstate = IDLE;
          end else if (state == LEN) begin
            if (RX_DATA == 8'd0 || RX_DATA > 8'(MAX_LEN)) begin
              err_n  = 1'b1;
              code_n = 3'd1;
              nstate = IDLE;
            end else begin
              ld_len = 1'b1;
              nstate = PAYLOAD;
            end
          end else if (state == PAYLOAD) begin
            wr = 1'b1;
            if (8'(idx) == last_idx)
              nstate = CSUM;
          end else begin
            if (8'(sum + RX_DATA) == 8'd0) begin
              nstate = DRAIN;
            end else begin
              err_n  = 1'b1;
              code_n = 3'd2;
              nstate = IDLE;
            end
          end
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          err_n  = 1'b1;
          code_n = 3'd3;
          nstate = IDLE;
        end
      end
      DRAIN: begin
        // Bytes arriving while draining are lost, never parsed.
        if (RX_VALID) begin
          err_n  = 1'b1;
          code_n = 3'd5;
        end
        if (hs && 8'(rd) == last_idx)
          nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHz) begin
    if (RESET) begin
      state     <= IDLE;
      len_q     <= 8'd0;
      idx       <= '0;
      rd        <= '0;
      sum       <= 8'd0;
      tcnt      <= '0;
      ERR       <= 1'b0;
      ERR_CODE  <= 3'd0;
      ERR_COUNT <= 8'd0;
    end else begin
      state <= nstate;
      if (nstate != state || RX_VALID || !run)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;
      if (ld_len) begin
        len_q <= RX_DATA;
        sum   <= RX_DATA;
        idx   <= '0;
      end else if (wr) begin
        sum <= sum + RX_DATA;
        idx <= idx + 1'b1;
      end
      if (state == CSUM && nstate == DRAIN)
        rd <= '0;
      else if (hs)
        rd <= rd + 1'b1;
      ERR <= err_n;
      if (err_n) begin
        ERR_CODE <= code_n;
        if (ERR_COUNT != 8'hFF)
          ERR_COUNT <= ERR_COUNT + 8'd1;
      end
    end
  end

  // Payload buffer keeps its contents across reset.
  always_ff @(posedge CLK50MHz) begin
    if (wr && !RESET)
      mem[idx] <= RX_DATA;
  end

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Self-checking bench for uart_rx_packet_ctrl: directed steps plus
// randomized packets compared against a packet-level reference model.
module tb_uart_rx_packet_ctrl;

  localparam int         ML = 8;
  localparam int         TO = 40;
  localparam logic [7:0] SY = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_perr = 1'b0;
  logic       pkt_ready = 1'b1;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_last;
  logic       err;
  logic [2:0] err_code;
  logic [7:0] err_count;

  uart_rx_packet_ctrl #(.MAX_LEN(ML), .TIMEOUT(TO), .SYNC(SY)) dut (
    .CLK50MHz (clk),
    .RESET    (rst),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .RX_PERR  (rx_perr),
    .PKT_DATA (pkt_data),
    .PKT_VALID(pkt_valid),
    .PKT_READY(pkt_ready),
    .PKT_LAST (pkt_last),
    .ERR      (err),
    .ERR_CODE (err_code),
    .ERR_COUNT(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nfail = 0;
  int ready_mode = 0;
  int tx_cyc = 0;
  int stall_viol = 0;
  int model_errs = 0;

  logic [7:0] got_data[$], exp_data[$], tx_q[$];
  logic       got_last[$], exp_last[$];
  logic [2:0] got_err[$], exp_err[$];
  int         got_cyc[$];

  logic       pv_p = 1'b0, pr_p = 1'b0, pl_p = 1'b0;
  logic [7:0] pd_p = 8'd0;

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       pkt_ready = 1'b1;
        1:       pkt_ready = 1'($urandom_range(0, 1));
        default: pkt_ready = ~pkt_ready;
      endcase
    end
  end

  always @(negedge clk) begin
    if (pkt_valid && pkt_ready) begin
      got_data.push_back(pkt_data);
      got_last.push_back(pkt_last);
      got_cyc.push_back(cyc);
    end
    if (err) got_err.push_back(err_code);
    if (pv_p && !pr_p &&
        (!pkt_valid || pkt_data !== pd_p || pkt_last !== pl_p))
      stall_viol++;
    pv_p = pkt_valid;
    pr_p = pkt_ready;
    pd_p = pkt_data;
    pl_p = pkt_last;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic p);
    @(posedge clk); #1;
    rx_data  = b;
    rx_perr  = p;
    rx_valid = 1'b1;
    tx_cyc   = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_perr  = 1'b0;
  endtask

  task automatic send_q();
    foreach (tx_q[i]) send(tx_q[i], 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 500) begin
      @(negedge clk);
      n++;
      if (pkt_valid) quiet = 0;
      else quiet++;
    end
    chk("drain_bound", 32'(pkt_valid), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic exp_pkt();
    foreach (tx_q[i]) begin
      exp_data.push_back(tx_q[i]);
      exp_last.push_back(i == tx_q.size() - 1);
    end
  endtask

  task automatic exp_e(input logic [2:0] c);
    exp_err.push_back(c);
    model_errs++;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_nbytes"}, 32'(got_data.size()), 32'(exp_data.size()));
    if (got_data.size() == exp_data.size()) begin
      foreach (exp_data[i]) begin
        chk({tag, "_data"}, 32'(got_data[i]), 32'(exp_data[i]));
        chk({tag, "_last"}, 32'(got_last[i]), 32'(exp_last[i]));
      end
    end
    chk({tag, "_nerr"}, 32'(got_err.size()), 32'(exp_err.size()));
    if (got_err.size() == exp_err.size()) begin
      foreach (exp_err[i])
        chk({tag, "_code"}, 32'(got_err[i]), 32'(exp_err[i]));
    end
    got_data.delete(); exp_data.delete();
    got_last.delete(); exp_last.delete();
    got_err.delete();  exp_err.delete();
    got_cyc.delete();
  endtask

  initial begin
    int len;
    logic [7:0] s, cs;
    logic bad_cs;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(pkt_valid), 32'(0));
    chk("rst_last",  32'(pkt_last),  32'(0));
    chk("rst_data",  32'(pkt_data),  32'(0));
    chk("rst_err",   32'(err),       32'(0));
    chk("rst_code",  32'(err_code),  32'(0));
    chk("rst_count", 32'(err_count), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    tx_q = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9D};
    send_q();
    wait_drain();
    if (got_cyc.size() == 3) begin
      chk("good_first_cyc", 32'(got_cyc[0]), 32'(tx_cyc + 1));
      chk("good_spacing",   32'(got_cyc[2]), 32'(got_cyc[0] + 2));
    end
    tx_q = '{8'h10, 8'h20, 8'h30};
    exp_pkt();
    check_stream("good");

    tx_q = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9E};
    send_q();
    idle(3);
    exp_e(3'd2);
    check_stream("csum");
    chk("csum_count", 32'(err_count), 32'(1));

    tx_q = '{8'hA5, 8'h00, 8'hA5, 8'h09, 8'hA5, 8'h01, 8'h55, 8'hAA};
    send_q();
    wait_drain();
    exp_e(3'd1);
    exp_e(3'd1);
    tx_q = '{8'h55};
    exp_pkt();
    check_stream("len");

    ready_mode = 2;
    tx_q = '{8'hA5, 8'h03, 8'h41, 8'h42, 8'h43, 8'h37};
    send_q();
    send(SY, 1'b0);
    wait_drain();
    ready_mode = 0;
    tx_q = '{8'h01, 8'h55, 8'hAA};
    send_q();
    idle(5);
    tx_q = '{8'h41, 8'h42, 8'h43};
    exp_pkt();
    exp_e(3'd5);
    check_stream("bp");
    chk("bp_stable", 32'(stall_viol), 32'(0));

    tx_q = '{8'hA5, 8'h02, 8'h11};
    send_q();
    idle(TO + 5);
    exp_e(3'd3);
    check_stream("timeout");

    send(SY, 1'b0);
    send(8'h02, 1'b1);
    idle(3);
    exp_e(3'd4);
    check_stream("parity");

    send(SY, 1'b0);
    send(8'h02, 1'b0);
    idle(TO - 2);
    tx_q = '{8'h11, 8'h22, 8'hCB};
    send_q();
    wait_drain();
    tx_q = '{8'h11, 8'h22};
    exp_pkt();
    check_stream("at_expiry");

    send(SY, 1'b0);
    send(8'h02, 1'b0);
    idle(TO - 1);
    send(8'h11, 1'b0);
    idle(3);
    exp_e(3'd3);
    check_stream("past_expiry");

    tx_q = '{8'hA5, 8'h04, 8'h01};
    send_q();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_errs = 0;
    chk("mid_rst_valid", 32'(pkt_valid), 32'(0));
    chk("mid_rst_last",  32'(pkt_last),  32'(0));
    chk("mid_rst_data",  32'(pkt_data),  32'(0));
    chk("mid_rst_err",   32'(err),       32'(0));
    chk("mid_rst_code",  32'(err_code),  32'(0));
    chk("mid_rst_count", 32'(err_count), 32'(0));
    tx_q = '{8'hA5, 8'h01, 8'h7E, 8'h81};
    send_q();
    wait_drain();
    tx_q = '{8'h7E};
    exp_pkt();
    check_stream("after_rst");

    ready_mode = 1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0)
        len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(ML + 1, 255));
      else
        len = int'($urandom_range(1, ML));
      send(SY, 1'b0);
      send(8'(len), 1'b0);
      if (len == 0 || len > ML) begin
        idle(2);
        exp_e(3'd1);
      end else begin
        tx_q.delete();
        s = 8'(len);
        for (int i = 0; i < len; i++) begin
          tx_q.push_back(8'($urandom_range(0, 255)));
          s = s + tx_q[i];
        end
        cs = 8'd0 - s;
        bad_cs = ($urandom_range(0, 3) == 0);
        if (bad_cs) cs = cs ^ 8'($urandom_range(1, 255));
        foreach (tx_q[i]) send(tx_q[i], 1'b0);
        send(cs, 1'b0);
        wait_drain();
        if (bad_cs) exp_e(3'd2);
        else exp_pkt();
      end
      check_stream("rand");
    end
    ready_mode = 0;

    chk("final_count", 32'(err_count),
        32'((model_errs > 255) ? 255 : model_errs));
    chk("final_stable", 32'(stall_viol), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
